hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Responder end of the decode stage's stall interface.
- Consumes the decoded source/target register fields of the instruction in decode, tracks destination registers of in-flight instructions in a DEPTH-slot shift register (EX, MEM, WB), and drives stall_out back to the decode stage's stall_in.
- Provides a saturating stall-cycle counter and a busy flag for debug and performance monitoring.

Parameters:
- DEPTH, 3, number of tracked in-flight slots (slot 0 = EX … slot DEPTH-1 = WB); legal range 2..8.
- WB_BYPASS, 1, if 1 the oldest slot is excluded from comparison because the register file is write-through; if 0 all slots compare.
- CNT_W, 16, width of stall_cnt_out.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable_in  in  1  pipeline advance enable; state frozen when low.
- flush_in  in  1  branch/redirect flush; clears all slots.
- dec_valid_in  in  1  decode holds a real instruction.
- dec_src_gp_in  in  4  GP source register read; 0 = none.
- dec_tgt_gp_in  in  4  GP target register read as operand; 0 = none.
- dec_src_sr_in  in  4  SR source read; 0 = none.
- dec_tgt_sr_in  in  4  SR target read; 0 = none.
- dec_wr_gp_in  in  4  GP register written by the decoding instruction; 0 = none.
- dec_wr_sr_in  in  4  SR written; 0 = none.
- stall_out  out  1  to decode stall_in; combinational.
- busy_out  out  1  any slot holds a pending write; registered-state derived.
- stall_cnt_out  out  CNT_W  saturating count of stalled enabled cycles.

Behaviour:
- Reset (rst_n low, asynchronous): all slot valid bits 0, slot registers 0, stall_cnt_out 0. stall_out = 0 and busy_out = 0 while reset is held.
- Slot contents: {valid, is_sr, reg[3:0]}. A write to register 0 never creates a slot entry (valid = 0), because 0 means "no register".
- Hazard:
  - stall_out = dec_valid_in AND, for some compared slot k, valid[k] and reg[k] equals a nonzero read field of the matching file: GP fields against !is_sr slots, SR fields against is_sr slots.
  - Compared slots are 0..DEPTH-2 when WB_BYPASS = 1, else 0..DEPTH-1.
  - stall_out does not depend on enable_in.
- Advance, on posedge clk when enable_in = 1:
  - Slots shift: slot k+1 <= slot k; slot DEPTH-1 retires.
  - Slot 0 <= issued entry if dec_valid_in and not stall_out, otherwise a bubble (valid = 0).
  - An instruction writing both GP and SR pushes a single entry for GP only. This is a decided limitation: SR-writes with a nonzero GP write are not produced by the ISA.
- enable_in = 0: slots and counter hold their values; stall_out is still evaluated.
- flush_in = 1 with enable_in = 1: all slots <= invalid and nothing is pushed. Flush wins over a simultaneous issue. The counter still counts if stall_out was high.
- Counter: increments when enable_in and stall_out; saturates at all-ones and does not wrap.
- Latency (DEPTH = 3, WB_BYPASS = 1): a dependent instruction immediately after its producer stalls exactly 2 cycles. It stalls 1 cycle with one independent instruction between them, and 0 cycles with two. With WB_BYPASS = 0 these become 3 / 2 / 1.
- busy_out = OR of all slot valid bits.
- Reset asserted mid-stall: stall_out drops asynchronously and slots clear. After release, no stale hazards remain.

Decomposition:
- Shared header src/hazard.vh holds:
  - slot field widths and the register-0 "none" constant;
  - slot bit offsets (VALID, IS_SR, REG[3:0]);
  - the default DEPTH.
- One sub-module, hazard_slot_cmp: combinational compare of one slot against the four read fields, producing a per-slot hit. It is instantiated in a generate loop.
- The shift register, counter and flush logic stay in the top module.

Test Plan:
- Reset: hold rst_n = 0 with dec_valid_in = 1 and all reads = 5 -> stall_out = 0, busy_out = 0, stall_cnt_out = 0. Release -> still no stall.
- RAW distance 1: issue wr_gp = 3, then next cycle src_gp = 3 -> stall_out high for exactly 2 cycles, then low; stall_cnt_out = 2. With WB_BYPASS = 0 -> 3 cycles.
- File separation and register 0: issue wr_sr = 3, then src_gp = 3 -> no stall. Issue wr_gp = 0, then src_gp = 0 -> no stall, busy_out stays 0.
- Distance 2: wr_gp = 7, an independent instruction, then tgt_gp = 7 -> 1 stall cycle.
- Flush: wr_gp = 4 issued, next cycle src_gp = 4 with flush_in = 1 -> stall_out = 1 that cycle. Next cycle all slots are empty, src_gp = 4 -> stall_out = 0.
- Freeze and saturation: enable_in = 0 during a stall -> slots and counter hold. Force counter to 0xFFFE with CNT_W = 16, stall 3 cycles -> count reads 0xFFFF and stays there.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg
//   Shared definitions for the decode-stage hazard scoreboard:
//   - register-field width and the register-0 "none" encoding
//   - slot layout {valid, is_sr, reg[3:0]} as a packed struct with the
//     matching bit offsets for anyone viewing the flat vector
//   - default tracking depth
//   - helper that turns the decoder's write fields into a slot entry
// ---------------------------------------------------------------------------
package hazard_scoreboard_pkg;

  localparam int REG_W         = 4;
  localparam int SLOT_W        = REG_W + 2;
  localparam logic [REG_W-1:0] REG_NONE = '0;

  // Bit offsets of the flattened slot vector.
  localparam int SLOT_VALID_BIT = SLOT_W - 1;
  localparam int SLOT_IS_SR_BIT = SLOT_W - 2;
  localparam int SLOT_REG_HI    = REG_W - 1;
  localparam int SLOT_REG_LO    = 0;

  localparam int DEFAULT_DEPTH = 3;

  typedef struct packed {
    logic             valid;
    logic             is_sr;
    logic [REG_W-1:0] rnum;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, is_sr: 1'b0, rnum: REG_NONE};

  // Build the entry an issuing instruction pushes. A GP write takes
  // precedence; the ISA never pairs a GP write with an SR write, so a
  // single entry per instruction is enough. Writes to register 0 create
  // no entry because 0 encodes "no register".
  function automatic slot_t make_entry(input logic [REG_W-1:0] wr_gp,
                                       input logic [REG_W-1:0] wr_sr);
    slot_t e;
    e = SLOT_EMPTY;
    if (wr_gp != REG_NONE) begin
      e.valid = 1'b1;
      e.is_sr = 1'b0;
      e.rnum  = wr_gp;
    end else if (wr_sr != REG_NONE) begin
      e.valid = 1'b1;
      e.is_sr = 1'b1;
      e.rnum  = wr_sr;
    end
    return e;
  endfunction

endpackage

// File: rtl/hazard_slot_cmp.sv
// ---------------------------------------------------------------------------
// hazard_slot_cmp
//   Combinational compare of one in-flight slot against the four read
//   fields of the instruction in decode.
//   Ports:
//     slot    in   slot_t  tracked destination {valid, is_sr, reg}
//     src_gp  in   4       GP source read field (0 = none)
//     tgt_gp  in   4       GP target-as-operand read field (0 = none)
//     src_sr  in   4       SR source read field (0 = none)
//     tgt_sr  in   4       SR target read field (0 = none)
//     hit     out  1       slot holds a pending write one of the reads needs
// ---------------------------------------------------------------------------
module hazard_slot_cmp
  import hazard_scoreboard_pkg::*;
(
  input  slot_t            slot,
  input  logic [REG_W-1:0] src_gp,
  input  logic [REG_W-1:0] tgt_gp,
  input  logic [REG_W-1:0] src_sr,
  input  logic [REG_W-1:0] tgt_sr,
  output logic             hit
);

  logic gp_match;
  logic sr_match;

  // A read field of 0 means "no read", so it must never match; slots never
  // hold register 0 with valid set, but the explicit guard keeps this block
  // correct on its own.
  always_comb begin
    gp_match = ((src_gp != REG_NONE) && (src_gp == slot.rnum)) ||
               ((tgt_gp != REG_NONE) && (tgt_gp == slot.rnum));
    sr_match = ((src_sr != REG_NONE) && (src_sr == slot.rnum)) ||
               ((tgt_sr != REG_NONE) && (tgt_sr == slot.rnum));
    hit      = slot.valid && (slot.is_sr ? sr_match : gp_match);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Responder side of the decode stage's stall interface. Tracks the
//   destination registers of in-flight instructions in a DEPTH-slot shift
//   register (slot 0 = EX ... slot DEPTH-1 = WB) and raises stall_out when
//   the instruction in decode reads a register still pending in a compared
//   slot.
//   Parameters:
//     DEPTH      tracked slots, 2..8
//     WB_BYPASS  1: oldest slot not compared (write-through register file)
//     CNT_W      width of the stall counter
//   Ports:
//     clk            in   1      pipeline clock
//     rst_n          in   1      asynchronous active-low reset
//     enable_in      in   1      pipeline advance enable
//     flush_in       in   1      clears all slots on an enabled edge
//     dec_valid_in   in   1      decode holds a real instruction
//     dec_src_gp_in  in   4      GP source read (0 = none)
//     dec_tgt_gp_in  in   4      GP target read (0 = none)
//     dec_src_sr_in  in   4      SR source read (0 = none)
//     dec_tgt_sr_in  in   4      SR target read (0 = none)
//     dec_wr_gp_in   in   4      GP register written (0 = none)
//     dec_wr_sr_in   in   4      SR register written (0 = none)
//     stall_out      out  1      combinational stall to decode
//     busy_out       out  1      any slot holds a pending write
//     stall_cnt_out  out  CNT_W  saturating count of stalled enabled cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_in,
  input  logic             flush_in,
  input  logic             dec_valid_in,
  input  logic [REG_W-1:0] dec_src_gp_in,
  input  logic [REG_W-1:0] dec_tgt_gp_in,
  input  logic [REG_W-1:0] dec_src_sr_in,
  input  logic [REG_W-1:0] dec_tgt_sr_in,
  input  logic [REG_W-1:0] dec_wr_gp_in,
  input  logic [REG_W-1:0] dec_wr_sr_in,
  output logic             stall_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] stall_cnt_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  slot_t            slot_reg [DEPTH];
  logic [DEPTH-1:0] hit_vec;
  logic [DEPTH-1:0] hit_used;
  logic [DEPTH-1:0] valid_vec;
  slot_t            issue_entry;
  logic             stall;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // -------------------------------------------------------------------------
  // Per-slot compare. With the write-through register file the oldest slot
  // has already delivered its value by the time decode reads, so it is
  // masked out of the hazard OR.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    hazard_slot_cmp u_cmp (
      .slot   (slot_reg[gi]),
      .src_gp (dec_src_gp_in),
      .tgt_gp (dec_tgt_gp_in),
      .src_sr (dec_src_sr_in),
      .tgt_sr (dec_tgt_sr_in),
      .hit    (hit_vec[gi])
    );

    if (WB_BYPASS && (gi == DEPTH - 1)) begin : g_masked
      assign hit_used[gi] = 1'b0;
    end else begin : g_compared
      assign hit_used[gi] = hit_vec[gi];
    end

    assign valid_vec[gi] = slot_reg[gi].valid;
  end

  // Stall is independent of enable_in so a frozen pipeline still holds
  // decode back.
  assign stall     = dec_valid_in && (|hit_used);
  assign stall_out = stall;
  assign busy_out  = |valid_vec;

  // A stalled or invalid decode slot enters the pipe as a bubble.
  always_comb begin
    issue_entry = SLOT_EMPTY;
    if (dec_valid_in && !stall) begin
      issue_entry = make_entry(dec_wr_gp_in, dec_wr_sr_in);
    end
  end

  // -------------------------------------------------------------------------
  // Shift register. Flush empties every slot and also discards the entry
  // that would otherwise have been pushed this edge.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_reg[gi] <= SLOT_EMPTY;
        end else if (enable_in) begin
          slot_reg[gi] <= flush_in ? SLOT_EMPTY : issue_entry;
        end
      end
    end else begin : g_body
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_reg[gi] <= SLOT_EMPTY;
        end else if (enable_in) begin
          slot_reg[gi] <= flush_in ? SLOT_EMPTY : slot_reg[gi-1];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stall counter: counts enabled stalled cycles (flush does not suppress
  // it) and sticks at all-ones.
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_next = cnt_reg;
    if (enable_in && stall && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign stall_cnt_out = cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed bench. Three scoreboards share one stimulus stream:
//     d : defaults (DEPTH 3, WB_BYPASS 1, CNT_W 16)
//     n : WB_BYPASS 0
//     s : CNT_W 2, so saturation is reached within a few stalls
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   1 more unit later, well before the next edge.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       enable_in;
  logic       flush_in;
  logic       dec_valid_in;
  logic [3:0] dec_src_gp_in;
  logic [3:0] dec_tgt_gp_in;
  logic [3:0] dec_src_sr_in;
  logic [3:0] dec_tgt_sr_in;
  logic [3:0] dec_wr_gp_in;
  logic [3:0] dec_wr_sr_in;

  logic        d_stall, d_busy;
  logic [15:0] d_cnt;
  logic        n_stall, n_busy;
  logic [15:0] n_cnt;
  logic        s_stall, s_busy;
  logic [1:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard u_d (
    .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .flush_in(flush_in),
    .dec_valid_in(dec_valid_in),
    .dec_src_gp_in(dec_src_gp_in), .dec_tgt_gp_in(dec_tgt_gp_in),
    .dec_src_sr_in(dec_src_sr_in), .dec_tgt_sr_in(dec_tgt_sr_in),
    .dec_wr_gp_in(dec_wr_gp_in), .dec_wr_sr_in(dec_wr_sr_in),
    .stall_out(d_stall), .busy_out(d_busy), .stall_cnt_out(d_cnt)
  );

  hazard_scoreboard #(.WB_BYPASS(1'b0)) u_n (
    .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .flush_in(flush_in),
    .dec_valid_in(dec_valid_in),
    .dec_src_gp_in(dec_src_gp_in), .dec_tgt_gp_in(dec_tgt_gp_in),
    .dec_src_sr_in(dec_src_sr_in), .dec_tgt_sr_in(dec_tgt_sr_in),
    .dec_wr_gp_in(dec_wr_gp_in), .dec_wr_sr_in(dec_wr_sr_in),
    .stall_out(n_stall), .busy_out(n_busy), .stall_cnt_out(n_cnt)
  );

  hazard_scoreboard #(.CNT_W(2)) u_s (
    .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .flush_in(flush_in),
    .dec_valid_in(dec_valid_in),
    .dec_src_gp_in(dec_src_gp_in), .dec_tgt_gp_in(dec_tgt_gp_in),
    .dec_src_sr_in(dec_src_sr_in), .dec_tgt_sr_in(dec_tgt_sr_in),
    .dec_wr_gp_in(dec_wr_gp_in), .dec_wr_sr_in(dec_wr_sr_in),
    .stall_out(s_stall), .busy_out(s_busy), .stall_cnt_out(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [3:0] sg, input logic [3:0] tg,
                     input logic [3:0] ss, input logic [3:0] ts,
                     input logic [3:0] wg, input logic [3:0] ws);
    dec_valid_in  = v;
    dec_src_gp_in = sg;
    dec_tgt_gp_in = tg;
    dec_src_sr_in = ss;
    dec_tgt_sr_in = ts;
    dec_wr_gp_in  = wg;
    dec_wr_sr_in  = ws;
    #1;
  endtask

  task automatic drain();
    dec(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    repeat (4) tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    enable_in = 1'b1;
    flush_in  = 1'b0;

    // ---- reset held with a reading instruction in decode ----
    dec(1'b1, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0, 4'd0);
    tick(); tick();
    chk("rst_stall", d_stall, 1'b0);
    chk("rst_busy",  d_busy,  1'b0);
    chk("rst_cnt",   d_cnt,   16'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_stall", d_stall, 1'b0);
    $display("step reset: stall=%0b busy=%0b cnt=%0d", d_stall, d_busy, d_cnt);
    drain();

    // ---- RAW distance 1 ----
    dec(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0);
    chk("raw1_prod_stall", d_stall, 1'b0);
    tick();
    dec(1'b1, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("raw1_c1_d", d_stall, 1'b1);
    chk("raw1_c1_n", n_stall, 1'b1);
    tick();
    chk("raw1_c2_d", d_stall, 1'b1);
    chk("raw1_c2_n", n_stall, 1'b1);
    tick();
    chk("raw1_c3_d", d_stall, 1'b0);
    chk("raw1_c3_n", n_stall, 1'b1);
    tick();
    chk("raw1_c4_n", n_stall, 1'b0);
    chk("raw1_cnt_d", d_cnt, 16'd2);
    chk("raw1_cnt_n", n_cnt, 16'd3);
    chk("raw1_cnt_s", s_cnt, 2'd2);
    $display("step raw1: cnt_d=%0d cnt_n=%0d cnt_s=%0d", d_cnt, n_cnt, s_cnt);
    drain();

    // ---- file separation: SR write must not block a GP read ----
    dec(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3);
    tick();
    dec(1'b1, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("sep_stall", d_stall, 1'b0);
    chk("sep_busy",  d_busy,  1'b1);
    dec(1'b1, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0);
    chk("sep_sr_stall", d_stall, 1'b1);
    $display("step sep: stall=%0b busy=%0b", d_stall, d_busy);
    dec(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    drain();
    chk("sep_drained", d_busy, 1'b0);

    // ---- register 0 never tracked ----
    dec(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    tick();
    dec(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("r0_stall", d_stall, 1'b0);
    chk("r0_busy",  d_busy,  1'b0);
    $display("step r0: stall=%0b busy=%0b", d_stall, d_busy);
    drain();

    // ---- distance 2 via target field ----
    dec(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd0);
    tick();
    dec(1'b1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("d2_indep", d_stall, 1'b0);
    tick();
    dec(1'b1, 4'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("d2_c1_d", d_stall, 1'b1);
    chk("d2_c1_n", n_stall, 1'b1);
    tick();
    chk("d2_c2_d", d_stall, 1'b0);
    chk("d2_c2_n", n_stall, 1'b1);
    tick();
    chk("d2_c3_n", n_stall, 1'b0);
    chk("d2_cnt_d", d_cnt, 16'd3);
    chk("d2_cnt_n", n_cnt, 16'd5);
    chk("d2_cnt_s", s_cnt, 2'd3);
    $display("step dist2: cnt_d=%0d cnt_n=%0d cnt_s=%0d", d_cnt, n_cnt, s_cnt);
    drain();

    // ---- flush during a stall ----
    dec(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd0);
    tick();
    flush_in = 1'b1;
    dec(1'b1, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("fl_stall", d_stall, 1'b1);
    tick();
    flush_in = 1'b0;
    dec(1'b1, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("fl_after_stall", d_stall, 1'b0);
    chk("fl_after_busy",  d_busy,  1'b0);
    chk("fl_cnt_d", d_cnt, 16'd4);
    chk("fl_cnt_n", n_cnt, 16'd6);
    chk("fl_cnt_s_sat", s_cnt, 2'd3);
    $display("step flush: stall=%0b cnt_d=%0d cnt_s=%0d", d_stall, d_cnt, s_cnt);
    drain();

    // ---- freeze during a stall ----
    dec(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9, 4'd0);
    tick();
    dec(1'b1, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    enable_in = 1'b0;
    #1;
    repeat (3) tick();
    chk("frz_stall", d_stall, 1'b1);
    chk("frz_busy",  d_busy,  1'b1);
    chk("frz_cnt",   d_cnt,   16'd4);
    $display("step freeze: stall=%0b cnt_d=%0d", d_stall, d_cnt);
    enable_in = 1'b1;
    #1;
    tick();
    chk("frz_go1", d_stall, 1'b1);
    tick();
    chk("frz_go2", d_stall, 1'b0);
    tick();
    chk("frz_cnt_d", d_cnt, 16'd6);
    chk("frz_cnt_n", n_cnt, 16'd9);
    chk("frz_cnt_s", s_cnt, 2'd3);
    drain();

    // ---- reset asserted mid-stall ----
    dec(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0);
    tick();
    dec(1'b1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("mrst_pre", d_stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mrst_stall", d_stall, 1'b0);
    chk("mrst_busy",  d_busy,  1'b0);
    chk("mrst_cnt",   d_cnt,   16'd0);
    tick();
    rst_n = 1'b1;
    #1;
    tick();
    chk("mrst_rel_stall", d_stall, 1'b0);
    chk("mrst_rel_n",     n_stall, 1'b0);
    $display("step midreset: stall=%0b busy=%0b cnt=%0d", d_stall, d_busy, d_cnt);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
